// File: rtl/mips_pkg.sv
// Shared mips32 pipeline definitions: opcodes, instruction field positions,
// the bubble word and the sequencer state type.
package mips_pkg;

    localparam logic [5:0] OP_LD   = 6'b110000;
    localparam logic [5:0] OP_ST   = 6'b110001;
    localparam logic [5:0] OP_BEQZ = 6'b110100;
    localparam logic [5:0] OP_BNEZ = 6'b110101;
    localparam logic [5:0] OP_HLT  = 6'b111111;

    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 26;
    localparam int RD_MSB  = 25;
    localparam int RD_LSB  = 21;
    localparam int RS1_MSB = 20;
    localparam int RS1_LSB = 16;
    localparam int RS2_MSB = 15;
    localparam int RS2_LSB = 11;

    // Word loaded into a pipeline register to turn it into a bubble.
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Decode-side bus of the hazard sequencer: ID instruction and EX branch flag
// in, pipeline-register controls and status out.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      ir_id;
    logic             br_taken;
    logic             pc_hold;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             clk_en;
    logic             halted;
    logic [CNT_W-1:0] stall_count;

    // Datapath side: presents the instruction and branch outcome.
    modport master (
        output ir_id, br_taken,
        input  pc_hold, ifid_flush, idex_bubble, clk_en, halted, stall_count
    );

    // Sequencer side.
    modport slave (
        input  ir_id, br_taken,
        output pc_hold, ifid_flush, idex_bubble, clk_en, halted, stall_count
    );
endinterface

// File: rtl/pipe_hazard_ctrl_scoreboard.sv
// In-flight destination tracker: shifts the ID writer through EX/MEM/WB
// slots and flags a RAW hazard when an ID source hits a checked slot.
module hazard_scoreboard
    import mips_pkg::*;
#(
    parameter int SB_DEPTH  = 3,
    parameter int WB_BYPASS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_en,
    input  logic        i_kill,
    input  logic [31:0] i_ir,
    output logic        o_hazard
);
    // Slots younger than this index are compared; WB is skipped when the
    // register bank writes before it reads.
    localparam int N_CHK = SB_DEPTH - WB_BYPASS;

    logic [5:0]          w_op;
    logic [4:0]          w_rd;
    logic [4:0]          w_rs1;
    logic [4:0]          w_rs2;
    logic                w_writer;
    logic                w_use_rs1;
    logic                w_use_rs2;
    logic                w_use_rd;
    logic                w_unused_bits;
    logic [SB_DEPTH-1:0] r_valid;
    logic [4:0]          r_reg [SB_DEPTH];
    logic [SB_DEPTH-1:0] w_match;

    assign w_op  = i_ir[OP_MSB:OP_LSB];
    assign w_rd  = i_ir[RD_MSB:RD_LSB];
    assign w_rs1 = i_ir[RS1_MSB:RS1_LSB];
    assign w_rs2 = i_ir[RS2_MSB:RS2_LSB];

    // Immediate bits and the oldest slot are not needed for matching.
    assign w_unused_bits = ^{i_ir[RS2_LSB-1:0], r_valid[SB_DEPTH-1], r_reg[SB_DEPTH-1]};

    // R0 is hard-wired, so an instruction targeting it never occupies a slot.
    assign w_writer  = (!w_op[5] || (w_op == OP_LD)) && (w_rd != 5'd0);
    assign w_use_rs1 = !w_op[5] || (w_op == OP_LD) || (w_op == OP_ST) ||
                       (w_op == OP_BEQZ) || (w_op == OP_BNEZ);
    assign w_use_rs2 = (w_op[5:4] == 2'b00);
    assign w_use_rd  = (w_op == OP_ST);

    // Advance the slots one stage; a killed or stalled ID enters as invalid.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid <= '0;
            for (int i = 0; i < SB_DEPTH; i++) begin
                r_reg[i] <= 5'd0;
            end
        end else if (i_en) begin
            r_valid[0] <= w_writer && !i_kill;
            r_reg[0]   <= w_rd;
            for (int i = 1; i < SB_DEPTH; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_reg[i]   <= r_reg[i-1];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < SB_DEPTH; gi++) begin : g_match
            if (gi < N_CHK) begin : g_chk
                assign w_match[gi] = r_valid[gi] && (
                    (w_use_rs1 && (w_rs1 != 5'd0) && (w_rs1 == r_reg[gi])) ||
                    (w_use_rs2 && (w_rs2 != 5'd0) && (w_rs2 == r_reg[gi])) ||
                    (w_use_rd  && (w_rd  != 5'd0) && (w_rd  == r_reg[gi])));
            end else begin : g_skip
                assign w_match[gi] = 1'b0;
            end
        end
    endgenerate

    assign o_hazard = |w_match;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: RAW stalls, taken-branch flushes and HALT drain for the
// 5-stage mips32 datapath. Runs on the ungated clock.
module pipe_hazard_ctrl
    import mips_pkg::*;
#(
    parameter int SB_DEPTH  = 3,
    parameter int WB_BYPASS = 1,
    parameter int CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_ctrl_if.slave  bus
);
    localparam int DC_W = $clog2(SB_DEPTH + 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [DC_W-1:0]  r_drain_cnt;
    logic [DC_W-1:0]  w_drain_next;
    logic [CNT_W-1:0] r_stall_count;
    logic             w_hazard;
    logic             w_is_halt;
    logic             w_sb_en;
    logic             w_pc_hold;
    logic             w_flush;
    logic             w_bubble;
    logic             w_clk_en;
    logic             w_halted;
    logic             w_stall_inc;

    assign w_is_halt = (bus.ir_id[OP_MSB:OP_LSB] == OP_HLT);
    assign w_sb_en   = (r_state != ST_HALTED);

    hazard_scoreboard #(
        .SB_DEPTH  (SB_DEPTH),
        .WB_BYPASS (WB_BYPASS)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .i_en     (w_sb_en),
        .i_kill   (w_flush | w_bubble),
        .i_ir     (bus.ir_id),
        .o_hazard (w_hazard)
    );

    // Next state and pipeline controls; branch beats HALT beats hazard.
    always_comb begin
        w_state_next = r_state;
        w_drain_next = r_drain_cnt;
        w_pc_hold    = 1'b0;
        w_flush      = 1'b0;
        w_bubble     = 1'b0;
        w_clk_en     = 1'b1;
        w_halted     = 1'b0;
        w_stall_inc  = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (bus.br_taken) begin
                    w_flush  = 1'b1;
                    w_bubble = 1'b1;
                end else if (w_is_halt) begin
                    w_pc_hold    = 1'b1;
                    w_flush      = 1'b1;
                    w_state_next = ST_DRAIN;
                    w_drain_next = DC_W'(SB_DEPTH);
                end else if (w_hazard) begin
                    w_pc_hold   = 1'b1;
                    w_bubble    = 1'b1;
                    w_stall_inc = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (bus.br_taken) begin
                    // An older branch in EX makes the HALT wrong-path.
                    w_flush      = 1'b1;
                    w_bubble     = 1'b1;
                    w_state_next = ST_RUN;
                    w_drain_next = '0;
                end else begin
                    w_pc_hold    = 1'b1;
                    w_flush      = 1'b1;
                    w_bubble     = 1'b1;
                    w_drain_next = r_drain_cnt - 1'b1;
                    if (r_drain_cnt == DC_W'(1)) begin
                        w_state_next = ST_HALTED;
                    end
                end
            end
            ST_HALTED: begin
                w_pc_hold = 1'b1;
                w_clk_en  = 1'b0;
                w_halted  = 1'b1;
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
        if (!rst) begin
            w_pc_hold   = 1'b0;
            w_flush     = 1'b0;
            w_bubble    = 1'b0;
            w_clk_en    = 1'b1;
            w_halted    = 1'b0;
            w_stall_inc = 1'b0;
        end
    end

    // Sequencer state and drain countdown.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_RUN;
            r_drain_cnt <= '0;
        end else begin
            r_state     <= w_state_next;
            r_drain_cnt <= w_drain_next;
        end
    end

    // Hazard-stall cycle counter, holds at all-ones.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_count <= '0;
        end else if (w_stall_inc && (r_stall_count != '1)) begin
            r_stall_count <= r_stall_count + 1'b1;
        end
    end

    assign bus.pc_hold     = w_pc_hold;
    assign bus.ifid_flush  = w_flush;
    assign bus.idex_bubble = w_bubble;
    assign bus.clk_en      = w_clk_en;
    assign bus.halted      = w_halted;
    assign bus.stall_count = r_stall_count;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios then random instruction
// streams, every cycle compared with a pipeline-occupancy reference model.
module tb_pipe_hazard_ctrl;
    import mips_pkg::*;

    localparam int SB_DEPTH  = 3;
    localparam int WB_BYPASS = 1;
    localparam int CNT_W     = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus();

    pipe_hazard_ctrl #(
        .SB_DEPTH  (SB_DEPTH),
        .WB_BYPASS (WB_BYPASS),
        .CNT_W     (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec  = 0;
    int n_miss = 0;
    int n_cyc  = 0;

    // Reference model: mode 0 = running, 1 = draining, 2 = halted.
    int       m_mode;
    int       m_drain;
    int       m_stalls;
    int       m_flight[$];   // destination register per stage, [0] = EX, 0 = none
    logic [4:0] m_last_ctl;  // {pc_hold, ifid_flush, idex_bubble, clk_en, halted}

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, n_cyc);
        end
    endtask

    function automatic logic [31:0] enc(input int op, input int d, input int a, input int b);
        return 32'((op << 26) | (d << 21) | (a << 16) | (b << 11));
    endfunction

    // Does any register the ID instruction reads sit in EX/MEM (WB bypassed)?
    function automatic bit model_hazard(input logic [31:0] ir);
        int op = int'(ir >> 26);
        int d  = int'((ir >> 21) & 32'd31);
        int a  = int'((ir >> 16) & 32'd31);
        int b  = int'((ir >> 11) & 32'd31);
        int srcs[$];
        if (op < 32 || op == 48 || op == 49 || op == 52 || op == 53) srcs.push_back(a);
        if (op < 16) srcs.push_back(b);
        if (op == 49) srcs.push_back(d);
        foreach (srcs[k]) begin
            if (srcs[k] != 0) begin
                for (int age = 0; age < SB_DEPTH - WB_BYPASS; age++) begin
                    if (m_flight[age] == srcs[k]) return 1'b1;
                end
            end
        end
        return 1'b0;
    endfunction

    task automatic model_step(input logic [31:0] ir, input logic br, input logic rs,
                              output logic [4:0] ctl);
        int op       = int'(ir >> 26);
        int d        = int'((ir >> 21) & 32'd31);
        int incoming = 0;
        int was_mode = m_mode;
        if (!rs) begin
            ctl      = 5'b00010;
            m_mode   = 0;
            m_drain  = 0;
            m_stalls = 0;
            m_flight = '{0, 0, 0};
            return;
        end
        case (m_mode)
            0: begin
                if (br) ctl = 5'b01110;
                else if (op == 63) begin
                    ctl = 5'b11010; m_mode = 1; m_drain = SB_DEPTH;
                end else if (model_hazard(ir)) begin
                    ctl = 5'b10110;
                    if (m_stalls < (1 << CNT_W) - 1) m_stalls++;
                end else begin
                    ctl = 5'b00010;
                    if ((op < 32 || op == 48) && d != 0) incoming = d;
                end
            end
            1: begin
                if (br) begin
                    ctl = 5'b01110; m_mode = 0;
                end else begin
                    ctl = 5'b11110; m_drain--;
                    if (m_drain == 0) m_mode = 2;
                end
            end
            default: ctl = 5'b10001;
        endcase
        if (was_mode != 2) begin
            m_flight.push_front(incoming);
            void'(m_flight.pop_back());
        end
    endtask

    // One clock: drive inputs after the edge, compare at the falling edge.
    task automatic cycle(input logic [31:0] ir, input logic br, input logic rs);
        logic [4:0]       exp_ctl;
        logic [4:0]       obs_ctl;
        logic [CNT_W-1:0] exp_cnt;
        @(posedge clk);
        #1;
        bus.ir_id    = ir;
        bus.br_taken = br;
        rst          = rs;
        @(negedge clk);
        n_cyc++;
        exp_cnt = CNT_W'(m_stalls);
        model_step(ir, br, rs, exp_ctl);
        m_last_ctl = exp_ctl;
        obs_ctl = {bus.pc_hold, bus.ifid_flush, bus.idex_bubble, bus.clk_en, bus.halted};
        check("ctl", 32'(obs_ctl), 32'(exp_ctl));
        check("stall_count", 32'(bus.stall_count), 32'(exp_cnt));
        $display("cyc %0d ir=%h br=%b rst=%b ctl=%b cnt=%0d", n_cyc, ir, br, rs, obs_ctl,
                 bus.stall_count);
    endtask

    // Hold an instruction in ID until it is no longer stalled.
    task automatic issue(input logic [31:0] ir, output int stalls);
        stalls = 0;
        for (int k = 0; k < 8; k++) begin
            cycle(ir, 1'b0, 1'b1);
            if (!bus.pc_hold) break;
            stalls++;
        end
    endtask

    task automatic nops(input int n);
        for (int k = 0; k < n; k++) cycle(NOP_WORD, 1'b0, 1'b1);
    endtask

    function automatic logic [31:0] rand_ir();
        int k = int'($urandom_range(0, 19));
        int op;
        case (k)
            0, 1, 2, 3, 4, 5, 17, 18: op = int'($urandom_range(0, 15));
            6, 7, 8:                  op = int'($urandom_range(16, 31));
            9, 10, 11:                op = 48;
            12, 13:                   op = 49;
            14:                       op = 52;
            15:                       op = 53;
            16:                       op = ($urandom_range(0, 3) == 0) ? 63 : 56;
            default:                  op = 58;
        endcase
        return enc(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 7))) | 32'($urandom_range(0, 2047));
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          stalls;
        int          base;
        int          n;
        int          bad;
        int          halted_run;
        logic [31:0] ir;
        logic        br;
        logic        rs;

        m_mode = 0; m_drain = 0; m_stalls = 0; m_flight = '{0, 0, 0};
        m_last_ctl = 5'b00010;
        rst = 1'b0; bus.ir_id = NOP_WORD; bus.br_taken = 1'b0;
        repeat (2) @(posedge clk);

        // Reset state.
        cycle(NOP_WORD, 1'b0, 1'b0);
        check("rst_clk_en", 32'(bus.clk_en), 32'd1);
        nops(2);

        // Back-to-back RAW on R3.
        base = int'(bus.stall_count);
        cycle(32'h0061_1000, 1'b0, 1'b1);
        issue(32'h0083_0000, stalls);
        check("raw_stall_cycles", 32'(stalls), 32'd2);
        check("raw_count", 32'(int'(bus.stall_count) - base), 32'd2);
        nops(3);

        // R0 destination and R0 source never stall.
        base = int'(bus.stall_count);
        cycle(32'h0001_0000, 1'b0, 1'b1);
        issue(32'h0080_0000, stalls);
        check("r0_stall_cycles", 32'(stalls), 32'd0);
        check("r0_count", 32'(int'(bus.stall_count) - base), 32'd0);
        nops(3);

        // Store reading rd and branch reading rs1 behind a load.
        cycle(32'hC0A1_0000, 1'b0, 1'b1);
        issue(32'hC4A2_0000, stalls);
        check("store_rd_stall", 32'(stalls), 32'd2);
        nops(3);
        cycle(32'hC0A1_0000, 1'b0, 1'b1);
        issue(32'hD005_0004, stalls);
        check("branch_rs1_stall", 32'(stalls), 32'd2);
        nops(3);

        // Taken branch over a hazarding writer: flush, no stall, writer dropped.
        base = int'(bus.stall_count);
        cycle(32'h0061_1000, 1'b0, 1'b1);
        cycle(enc(0, 6, 3, 0), 1'b1, 1'b1);
        check("br_flush", 32'({bus.pc_hold, bus.ifid_flush, bus.idex_bubble}), 32'b011);
        check("br_count", 32'(int'(bus.stall_count) - base), 32'd0);
        cycle(enc(0, 7, 6, 0), 1'b0, 1'b1);
        check("br_sb0_invalid", 32'(bus.pc_hold), 32'd0);
        nops(3);

        // HALT: three drain cycles, then stays halted until reset.
        cycle(32'hFC00_0000, 1'b0, 1'b1);
        n = 0;
        for (int k = 0; k < 10; k++) begin
            cycle(NOP_WORD, 1'b0, 1'b1);
            if (bus.halted) break;
            n++;
        end
        check("drain_cycles", 32'(n), 32'd3);
        n = 0;
        for (int k = 0; k < 10; k++) begin
            cycle(NOP_WORD, 1'b0, 1'b1);
            if (bus.halted && !bus.clk_en) n++;
        end
        check("halted_hold", 32'(n), 32'd10);
        cycle(NOP_WORD, 1'b0, 1'b0);
        cycle(NOP_WORD, 1'b0, 1'b1);
        check("post_rst_state", 32'({bus.clk_en, bus.halted}), 32'b10);
        check("post_rst_count", 32'(bus.stall_count), 32'd0);

        // HALT aborted by a branch on the first drain cycle.
        nops(2);
        cycle(32'hFC00_0000, 1'b0, 1'b1);
        cycle(NOP_WORD, 1'b1, 1'b1);
        check("abort_ctl", 32'({bus.pc_hold, bus.ifid_flush, bus.idex_bubble}), 32'b011);
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            cycle(NOP_WORD, 1'b0, 1'b1);
            if (bus.halted || !bus.clk_en) bad++;
        end
        check("abort_no_halt", 32'(bad), 32'd0);

        // Random streams; a stalled instruction stays in ID.
        ir = NOP_WORD;
        halted_run = 0;
        for (int i = 0; i < 1500; i++) begin
            if (!(m_last_ctl[4] && !m_last_ctl[3])) ir = rand_ir();
            br = ($urandom_range(0, 99) < 12);
            rs = !(($urandom_range(0, 99) < 2) || (halted_run >= 4));
            cycle(ir, br, rs);
            halted_run = (m_mode == 2) ? halted_run + 1 : 0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Pipeline sequencer for the 5-stage mips32 datapath (IF/ID/EX/MEM/WB).
- Tracks in-flight destination registers in a 3-entry scoreboard.
- Stalls IF/ID on RAW hazards and flushes wrong-path instructions when EX resolves a taken branch.
- Drains the pipeline on HALT, then drops the datapath clock enable.
- Sits beside decode. Consumes the ID-stage instruction word and the EX branch-taken flag. Drives the hold, flush and bubble controls of the pipeline registers.

Parameters:
SB_DEPTH, 3, number of in-flight stages tracked after ID (EX, MEM, WB)
WB_BYPASS, 1, 1 = register bank is written before read, so a WB-stage match does not stall
CNT_W, 16, width of the saturating stall counter

Ports:
clk  input  1  datapath clock, rising edge
rst  input  1  synchronous, active-low reset
ir_id  input  32  instruction currently in ID
br_taken  input  1  EX-stage branch condition true (sel)
pc_hold  output  1  PC and IF/ID register keep their value
ifid_flush  output  1  IF/ID register loads 32'h0
idex_bubble  output  1  ID/EX register loads a bubble (IR = 32'h0)
clk_en  output  1  datapath clock enable (gate = clk & clk_en)
halted  output  1  HALTED state reached
stall_count  output  CNT_W  saturating count of hazard-stall cycles

Behaviour:
Decode (combinational, from ir_id; op = ir_id[31:26]):
- Writer: op[5]==0 (ALU), or op==6'b110000 (load). Destination = ir_id[25:21]. Never a writer when the destination is 0.
- Source rs1 = ir_id[20:16]: used by ALU, load, store and branch.
- Source rs2 = ir_id[15:11]: used only when op[5:4]==2'b00 (RR ALU).
- Source rd = ir_id[25:21]: used by store (6'b110001).
- HALT: op==6'b111111. HALT has no sources.
- R0 sources never match.

Scoreboard:
- Entries sb[0..SB_DEPTH-1], each {valid, reg[4:0]}; sb[0] is EX.
- Each enabled edge: sb[i] <= sb[i-1] for i ≥ 1.
- sb[0] <= writer info of ir_id. It becomes invalid if stall, ifid_flush or idex_bubble is asserted that cycle.
- Hazard = any used source equals a valid sb[i].reg, for i < SB_DEPTH-WB_BYPASS.

FSM states: RUN, DRAIN, HALTED. Priority is br_taken > HALT > hazard.
- RUN, br_taken=1: ifid_flush=1, idex_bubble=1, pc_hold=0 (PC loads the target). Stay in RUN. Hazard and HALT in ID are ignored, since both are wrong-path.
- RUN, HALT in ID and br_taken=0: pc_hold=1, ifid_flush=1. HALT itself passes to ID/EX as a bubble. Go to DRAIN and load drain_cnt = SB_DEPTH.
- RUN, hazard and br_taken=0: pc_hold=1, idex_bubble=1, stall_count += 1 (saturates at all-ones).
- RUN, otherwise: all controls 0.
- DRAIN: pc_hold=1, ifid_flush=1, idex_bubble=1. drain_cnt decrements each cycle.
  - br_taken=1 in DRAIN (an older branch in EX): abort the halt, go to RUN. That cycle's outputs are the RUN br_taken outputs.
  - drain_cnt==1 and br_taken=0: go to HALTED.
- HALTED: clk_en=0, halted=1, pc_hold=1. Scoreboard is frozen. Only rst exits.

Clocking and reset:
- The block itself runs on ungated clk.
- clk_en=1 in RUN and DRAIN.
- All state updates on the rising edge.
- rst==0 at the edge, including mid-DRAIN or in HALTED, gives: state=RUN, scoreboard all invalid, drain_cnt=0, stall_count=0.
- Output values while in reset: clk_en=1, halted=0, pc_hold=0, ifid_flush=0, idex_bubble=0.

Decomposition:
- Shared package mips_pkg: opcode constants (OP_LD=6'b110000, OP_ST=6'b110001, OP_BEQZ=6'b110100, OP_BNEZ=6'b110101, OP_HLT=6'b111111), instruction field bit positions, the NOP/bubble word 32'h0, and the FSM state typedef.
- One sub-module, hazard_scoreboard: shift register plus match logic, outputs the hazard flag. FSM and counters stay in the top.

Test Plan:
- Back-to-back RAW: 0x00611000 (add R3,R1,R2) then 0x00830000 (add R4,R3,R0) with WB_BYPASS=1 -> pc_hold and idex_bubble high exactly 2 cycles, stall_count=2, second instruction enters EX on cycle 3.
- R0 and no-dependency: 0x00010000 (writes R0) then 0x00800000 (reads R0) -> no stall, stall_count stays 0.
- Store source check: load R5 (0xC0A10000) then store reading rd=R5 (0xC4A20000) -> 2-cycle stall. Branch reading R5 (0xD0050004) behind the load -> 2-cycle stall.
- Taken branch: br_taken=1 while ir_id holds a hazarding instruction -> ifid_flush=1 and idex_bubble=1 for 1 cycle, pc_hold=0, stall_count unchanged, sb[0] invalid next cycle.
- Halt: 0xFC000000 in ID -> DRAIN for 3 cycles, then halted=1 and clk_en=0. A further 10 cycles stay HALTED. rst=0 for 1 cycle -> RUN, clk_en=1, stall_count=0.
- Halt abort: br_taken=1 on the 1st DRAIN cycle -> state returns to RUN, halted never asserts, clk_en stays 1.
